mem_buffer_reg: RTL

//   Parametrised clocked memory buffer register between the CPU datapath and memory.

---
 rtl/mem_buffer_reg_if.sv | 32 +++
 rtl/mem_buffer_reg.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_buffer_reg_if.sv
// rtl/mem_buffer_reg_if.sv - CPU bus and memory handshake signals of the memory buffer register
interface mem_buffer_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]   busDataIn;
  logic [DATA_WIDTH/8-1:0] byteEn;
  logic                    busLoad;
  logic                    memRead;
  logic                    memWrite;
  logic [ADDR_WIDTH-1:0]   addrIn;
  logic [DATA_WIDTH-1:0]   memDataIn;
  logic                    memAck;
  logic                    memReq;
  logic                    memWe;
  logic [ADDR_WIDTH-1:0]   memAddr;
  logic [DATA_WIDTH-1:0]   memDataOut;
  logic [DATA_WIDTH-1:0]   dataOut;
  logic                    busy;
  logic                    done;
  logic                    error;

  modport master (
    output busDataIn, byteEn, busLoad, memRead, memWrite, addrIn, memDataIn, memAck,
    input  memReq, memWe, memAddr, memDataOut, dataOut, busy, done, error
  );

  modport slave (
    input  busDataIn, byteEn, busLoad, memRead, memWrite, addrIn, memDataIn, memAck,
    output memReq, memWe, memAddr, memDataOut, dataOut, busy, done, error
  );
endinterface

// File: rtl/mem_buffer_reg.sv
// rtl/mem_buffer_reg.sv - memory buffer register with byte-masked bus load and timed memory transactions
module mem_buffer_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             resetN,
  mem_buffer_reg_if.slave  bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t                state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic                  req_q, req_n;
  logic                  we_q, we_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      wdata_q <= wdata_n;
      addr_q  <= addr_n;
      req_q   <= req_n;
      we_q    <= we_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    wdata_n = wdata_q;
    addr_n  = addr_q;
    req_n   = req_q;
    we_n    = we_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    err_n   = err_q;
    case (state_q)
      IDLE: begin
        // Only the highest-priority request is taken; the others are dropped.
        if (bus.memRead || bus.memWrite) begin
          state_n = bus.memRead ? RD : WR;
          addr_n  = bus.addrIn;
          req_n   = 1'b1;
          we_n    = !bus.memRead;
          busy_n  = 1'b1;
          err_n   = 1'b0;
          cnt_n   = '0;
          if (!bus.memRead) wdata_n = data_q;
        end else if (bus.busLoad) begin
          for (int i = 0; i < NB; i++) begin
            if (bus.byteEn[i]) data_n[8*i +: 8] = bus.busDataIn[8*i +: 8];
          end
        end
      end
      RD, WR: begin
        // An ack arriving on the limit edge is checked first, so it wins over the timeout.
        if (bus.memAck || cnt_q == CW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          req_n   = 1'b0;
          we_n    = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
          if (!bus.memAck) err_n = 1'b1;
          else if (state_q == RD) data_n = bus.memDataIn;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.memReq     = req_q;
  assign bus.memWe      = we_q;
  assign bus.memAddr    = addr_q;
  assign bus.memDataOut = wdata_q;
  assign bus.dataOut    = data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;
endmodule
